// File: rtl/fir_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : fir_filter_bank
// Brief    : Twelve parallel LPC predictors (orders 1..12) scoring one block by
//            total absolute residual; reports the order with the smallest sum.
//            Optional macro FIR_FB_SAT_ACC_EN: saturating accumulators.
// Revision : 1.0 - initial release
// ============================================================================
module fir_filter_bank #(
    parameter int BLOCK_SIZE = 4096,
    parameter int QLP_SHIFT  = 10,
    parameter int ACC_W      = 32
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iEnable,
    input  logic               iLoad,
    input  logic [3:0]         iM,
    input  logic signed [15:0] iCoeff,
    input  logic               iValid,
    input  logic signed [15:0] iSample,
    output logic [3:0]         oBestPredictor,
    output logic               oValid
);

    localparam int c_NUM_FILT = 12;
    localparam int c_SC_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    logic signed [15:0] r_hist [c_NUM_FILT];
    logic [c_SC_W-1:0]  r_sc;
    logic               w_accept;
    logic               w_last;
    logic [ACC_W-1:0]   w_acc_next [c_NUM_FILT];
    logic [ACC_W-1:0]   r_snap [c_NUM_FILT];
    logic               r_v0, r_v1, r_v2;
    logic [ACC_W-1:0]   r_s1_val [6];
    logic [3:0]         r_s1_idx [6];
    logic [ACC_W-1:0]   r_s2_val [3];
    logic [3:0]         r_s2_idx [3];
    logic [ACC_W-1:0]   w_best_val;
    logic [3:0]         w_best;

    assign w_accept = iEnable & iValid;
    assign w_last   = w_accept && (r_sc == c_SC_W'(BLOCK_SIZE - 1));

    // r_hist[0] is x[n-1]; the history restarts from zero at every block boundary
    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_sc <= '0;
            for (int k = 0; k < c_NUM_FILT; k++) r_hist[k] <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_sc <= '0;
                for (int k = 0; k < c_NUM_FILT; k++) r_hist[k] <= '0;
            end else begin
                r_sc      <= r_sc + 1'b1;
                r_hist[0] <= iSample;
                for (int k = 1; k < c_NUM_FILT; k++) r_hist[k] <= r_hist[k-1];
            end
        end
    end

    for (genvar gm = 1; gm <= c_NUM_FILT; gm++) begin : g_filt
        logic signed [15:0] r_coeff [gm];
        logic [3:0]         r_lc;
        logic [ACC_W-1:0]   r_acc;
        logic signed [31:0] w_prod [gm];
        logic signed [35:0] w_sum;
        logic signed [35:0] w_pred;
        logic signed [36:0] w_res;
        logic [36:0]        w_abs;
        logic               w_warm;
        logic               w_load;

        assign w_load = iEnable & iLoad & (iM == 4'(gm));
        assign w_warm = (r_sc < c_SC_W'(gm));

        always_comb begin
            w_sum = '0;
            for (int k = 0; k < gm; k++) begin
                w_prod[k] = 32'(r_coeff[k]) * 32'(r_hist[k]);
                w_sum     = w_sum + 36'(w_prod[k]);
            end
        end

        assign w_pred = w_sum >>> QLP_SHIFT;
        assign w_res  = 37'(iSample) - 37'(w_pred);
        assign w_abs  = w_res[36] ? $unsigned(-w_res) : $unsigned(w_res);

`ifdef FIR_FB_SAT_ACC_EN
        localparam int c_EXT_W = ((ACC_W > 37) ? ACC_W : 37) + 1;
        logic [c_EXT_W-1:0] w_ext;
        assign w_ext = c_EXT_W'(r_acc) + (w_warm ? '0 : c_EXT_W'(w_abs));
        // clamp so an overflowing filter keeps the worst possible score
        assign w_acc_next[gm-1] = (w_ext > c_EXT_W'({ACC_W{1'b1}})) ?
                                  {ACC_W{1'b1}} : ACC_W'(w_ext);
`else
        assign w_acc_next[gm-1] = r_acc + (w_warm ? '0 : ACC_W'(w_abs));
`endif

        always_ff @(posedge iClock) begin
            if (iReset) begin
                r_acc <= '0;
                r_lc  <= '0;
                for (int k = 0; k < gm; k++) r_coeff[k] <= '0;
            end else begin
                if (w_accept) r_acc <= w_last ? '0 : w_acc_next[gm-1];
                if (w_load) begin
                    for (int k = 0; k < gm; k++)
                        if (r_lc == 4'(k)) r_coeff[k] <= iCoeff;
                    r_lc <= (r_lc == 4'(gm - 1)) ? 4'd0 : r_lc + 4'd1;
                end
            end
        end
    end

    // Final 3->1 stage; strict compares keep the lower order on ties
    always_comb begin
        w_best_val = r_s2_val[0];
        w_best     = r_s2_idx[0];
        if (r_s2_val[1] < w_best_val) begin
            w_best_val = r_s2_val[1];
            w_best     = r_s2_idx[1];
        end
        if (r_s2_val[2] < w_best_val) begin
            w_best_val = r_s2_val[2];
            w_best     = r_s2_idx[2];
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_v0           <= 1'b0;
            r_v1           <= 1'b0;
            r_v2           <= 1'b0;
            oValid         <= 1'b0;
            oBestPredictor <= '0;
            for (int k = 0; k < c_NUM_FILT; k++) r_snap[k] <= '0;
            for (int i = 0; i < 6; i++) begin
                r_s1_val[i] <= '0;
                r_s1_idx[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                r_s2_val[i] <= '0;
                r_s2_idx[i] <= '0;
            end
        end else if (iEnable) begin
            r_v0 <= w_last;
            if (w_last)
                for (int k = 0; k < c_NUM_FILT; k++) r_snap[k] <= w_acc_next[k];
            for (int i = 0; i < 6; i++) begin
                if (r_snap[2*i+1] < r_snap[2*i]) begin
                    r_s1_val[i] <= r_snap[2*i+1];
                    r_s1_idx[i] <= 4'(2*i + 2);
                end else begin
                    r_s1_val[i] <= r_snap[2*i];
                    r_s1_idx[i] <= 4'(2*i + 1);
                end
            end
            r_v1 <= r_v0;
            for (int i = 0; i < 3; i++) begin
                if (r_s1_val[2*i+1] < r_s1_val[2*i]) begin
                    r_s2_val[i] <= r_s1_val[2*i+1];
                    r_s2_idx[i] <= r_s1_idx[2*i+1];
                end else begin
                    r_s2_val[i] <= r_s1_val[2*i];
                    r_s2_idx[i] <= r_s1_idx[2*i];
                end
            end
            r_v2   <= r_v1;
            oValid <= r_v2;
            if (r_v2) oBestPredictor <= w_best;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_filter_bank
// Brief    : Scoreboard bench for fir_filter_bank with a block-level residual
//            model; random and directed blocks, resets, loads and stalls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_filter_bank;

    localparam int BLOCK_SIZE = 4096;
    localparam int QLP_SHIFT  = 10;
    localparam int ACC_W      = 32;

    logic               iClock  = 1'b0;
    logic               iReset  = 1'b1;
    logic               iEnable = 1'b0;
    logic               iLoad   = 1'b0;
    logic [3:0]         iM      = '0;
    logic signed [15:0] iCoeff  = '0;
    logic               iValid  = 1'b0;
    logic signed [15:0] iSample = '0;
    logic [3:0]         oBestPredictor;
    logic               oValid;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    // reference model state
    int     mc   [13][12];
    int     mlc  [13];
    longint macc [13];
    int     bx   [BLOCK_SIZE];
    int     msc;
    int     exp_best_q [$];
    longint exp_cyc_q  [$];
    int     mon_eb;
    longint mon_ec;

    fir_filter_bank #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .QLP_SHIFT  (QLP_SHIFT),
        .ACC_W      (ACC_W)
    ) dut (
        .iClock         (iClock),
        .iReset         (iReset),
        .iEnable        (iEnable),
        .iLoad          (iLoad),
        .iM             (iM),
        .iCoeff         (iCoeff),
        .iValid         (iValid),
        .iSample        (iSample),
        .oBestPredictor (oBestPredictor),
        .oValid         (oValid)
    );

    always #5 iClock = ~iClock;
    always @(posedge iClock) cyc <= cyc + 1;

    function automatic void model_reset();
        for (int m = 0; m < 13; m++) begin
            for (int k = 0; k < 12; k++) mc[m][k] = 0;
            mlc[m]  = 0;
            macc[m] = 0;
        end
        msc = 0;
    endfunction

    function automatic void model_load(int m, int cf);
        if (m >= 1 && m <= 12) begin
            mc[m][mlc[m]] = cf;
            mlc[m] = (mlc[m] + 1) % m;
        end
    endfunction

    function automatic void model_sample(int x);
        longint sum, pred, res, lim;
        int     best;
        lim = longint'(1) << ACC_W;
        for (int m = 1; m <= 12; m++) begin
            sum = 0;
            for (int k = 0; k < m; k++)
                if (msc - 1 - k >= 0) sum += longint'(mc[m][k]) * bx[msc-1-k];
            pred = sum >>> QLP_SHIFT;
            res  = x - pred;
            if (res < 0) res = -res;
            if (msc >= m) begin
`ifdef FIR_FB_SAT_ACC_EN
                macc[m] = (macc[m] + res > lim - 1) ? lim - 1 : macc[m] + res;
`else
                macc[m] = (macc[m] + res) % lim;
`endif
            end
        end
        bx[msc] = x;
        msc++;
        if (msc == BLOCK_SIZE) begin
            best = 1;
            for (int m = 2; m <= 12; m++) if (macc[m] < macc[best]) best = m;
            exp_best_q.push_back(best);
            exp_cyc_q.push_back(cyc + 4);
            for (int m = 0; m < 13; m++) macc[m] = 0;
            msc = 0;
        end
    endfunction

    task automatic step(input bit en, input bit vld, input int x,
                        input bit ld, input int m, input int cf);
        @(negedge iClock);
        iEnable = en;
        iValid  = vld;
        iSample = 16'(x);
        iLoad   = ld;
        iM      = 4'(m);
        iCoeff  = 16'(cf);
        if (en) begin
            if (vld) model_sample(x);
            if (ld)  model_load(m, cf);
        end
    endtask

    task automatic load(input int m, input int cf);
        step(1'b1, 1'b0, 0, 1'b1, m, cf);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge iClock);
        iReset  = 1'b1;
        iEnable = 1'b1;
        iValid  = 1'b0;
        iLoad   = 1'b0;
        exp_best_q.delete();
        exp_cyc_q.delete();
        model_reset();
        @(negedge iClock);
        checks += 2;
        if (oBestPredictor !== 4'd0) begin
            errors++;
            $display("FAIL reset_best: got %0d, required 0", oBestPredictor);
        end
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b, required 0", oValid);
        end
        iReset = 1'b0;
    endtask

    function automatic int srand(int a);
        return int'($urandom_range(0, 2 * a)) - a;
    endfunction

    // scoreboard monitor: every oValid pulse consumes exactly one expectation
    always @(negedge iClock) begin
        if (!iReset && oValid) begin
            if (exp_best_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: oValid=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_eb = exp_best_q.pop_front();
                mon_ec = exp_cyc_q.pop_front();
                checks += 2;
                if (oBestPredictor !== 4'(mon_eb)) begin
                    errors++;
                    $display("FAIL best_order: got %0d, required %0d", oBestPredictor, mon_eb);
                end
                if (cyc != mon_ec) begin
                    errors++;
                    $display("FAIL result_latency: pulse at cycle %0d, required %0d", cyc, mon_ec);
                end
            end
        end
    end

    initial begin
        int acc_n;
        model_reset();
        repeat (3) @(negedge iClock);
        checks += 2;
        if (oBestPredictor !== 4'd0) begin
            errors++;
            $display("FAIL por_best: got %0d, required 0", oBestPredictor);
        end
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL por_valid: got %0b, required 0", oValid);
        end

        // reset mid-block: nothing may come out afterwards
        do_reset();
        load(1, 1024);
        for (int n = 0; n < 1000; n++) step(1'b1, 1'b1, srand(3000), 1'b0, 0, 0);
        do_reset();
        idle(10);

        // constant input, order 1 is an exact predictor
        do_reset();
        load(1, 1024);
        for (int n = 0; n < BLOCK_SIZE; n++) step(1'b1, 1'b1, 100, 1'b0, 0, 0);
        idle(6);

        // ramp: order 2 extrapolates exactly
        do_reset();
        load(1, 1024);
        load(2, 2048);
        load(2, -1024);
        for (int n = 0; n < BLOCK_SIZE; n++) step(1'b1, 1'b1, n, 1'b0, 0, 0);
        idle(6);

        // tie: zero coefficients and zero warm-up samples make every sum equal
        do_reset();
        for (int n = 0; n < BLOCK_SIZE; n++)
            step(1'b1, 1'b1, (n < 12) ? 0 : int'($urandom_range(1, 5000)), 1'b0, 0, 0);
        idle(6);

        // load wrap on order 3, ignored loads, and a stall mid-block
        do_reset();
        for (int i = 0; i < 6; i++) load(3, srand(1500));
        load(0, 777);
        load(13, -777);
        load(1, 900);
        for (int n = 0; n < BLOCK_SIZE; n++) begin
            if (n == 2000)
                repeat (5) step(1'b0, 1'b1, srand(30000), 1'b1, 3, srand(30000));
            step(1'b1, 1'b1, srand(2000) + ((n % 64) * 20), 1'b0, 0, 0);
        end
        idle(6);

        // back-to-back blocks, then a third block interrupted during compare
        do_reset();
        for (int m = 1; m <= 12; m++)
            for (int k = 0; k < m; k++) load(m, srand(1024));
        for (int n = 0; n < 2 * BLOCK_SIZE; n++)
            step(1'b1, 1'b1, (n < BLOCK_SIZE) ? srand(8000) : srand(300) + 1000, 1'b0, 0, 0);
        for (int n = 0; n < BLOCK_SIZE; n++) step(1'b1, 1'b1, srand(5000), 1'b0, 0, 0);
        idle(1);
        do_reset();
        idle(10);

        // random gaps, full-range data, loads concurrent with samples
        do_reset();
        for (int m = 1; m <= 12; m++)
            for (int k = 0; k < m; k++) load(m, srand(32767));
        acc_n = 0;
        while (acc_n < BLOCK_SIZE) begin
            bit v, l;
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 9) == 0);
            step(1'b1, v, srand(32767), l, int'($urandom_range(0, 15)), srand(32767));
            if (v) acc_n++;
        end
        idle(8);

        checks++;
        if (exp_best_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_best_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
